// File: rtl/instruction_memory.sv
// Instruction memory: DEPTH words of 32 bits, combinational fetch by byte
// address, synchronous word writes for program loading, and a synchronous
// active-low reset that restores the built-in program image.
module instruction_memory #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  output logic [31:0] instruction,
  input  logic        we,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata
);

  localparam int          AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Built-in program image; every word not listed is a NOP.
  function automatic logic [31:0] default_word(input int idx);
    logic [31:0] word;
    case (idx)
      0:       word = 32'h0050_0113;
      1:       word = 32'h0070_0193;
      2:       word = 32'h0631_0463;
      3:       word = 32'h0031_01b3;
      4:       word = 32'h0031_62b3;
      5:       word = 32'h0031_72b3;
      6:       word = 32'h0031_42b3;
      7:       word = 32'h0001_2503;
      8:       word = 32'h00a1_2223;
      9:       word = 32'h4031_43b3;
      default: word = NOP;
    endcase
    return word;
  endfunction

  // Storage holds the program image from power-up, before any clock or reset.
  logic [31:0] mem_r [DEPTH] = '{
    0:       32'h0050_0113,
    1:       32'h0070_0193,
    2:       32'h0631_0463,
    3:       32'h0031_01b3,
    4:       32'h0031_62b3,
    5:       32'h0031_72b3,
    6:       32'h0031_42b3,
    7:       32'h0001_2503,
    8:       32'h00a1_2223,
    9:       32'h4031_43b3,
    default: 32'h0000_0013
  };

  // Word indices widened to 32 bits so the range check against DEPTH is
  // done on the full index: no aliasing of large addresses onto low words.
  logic [31:0] ridx_s;
  logic [31:0] widx_s;
  logic        rd_in_range_s;
  logic        wr_in_range_s;
  logic        unused_s;

  assign ridx_s        = {2'b00, addr[31:2]};
  assign widx_s        = {2'b00, waddr[31:2]};
  assign rd_in_range_s = (ridx_s < DEPTH);
  assign wr_in_range_s = (widx_s < DEPTH);
  // Byte-offset bits are intentionally ignored on both ports.
  assign unused_s      = ^{addr[1:0], waddr[1:0]};

  // Combinational fetch; out-of-range indices return a NOP, never X.
  always_comb begin
    instruction = NOP;
    if (rd_in_range_s) begin
      instruction = mem_r[ridx_s[AW-1:0]];
    end else begin
      instruction = NOP;
    end
  end

  // Reset restores the image (and discards a coincident write); otherwise
  // an in-range write updates one word at the edge, with no read bypass.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= default_word(i);
      end
    end else if (we && wr_in_range_s) begin
      mem_r[widx_s[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory: directed steps, expected words
// queued when stimulus is applied and compared when the output has settled.
module tb_instruction_memory;

  localparam int DEPTH = 256;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        clk_en;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] instruction;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          vectors;
  int          fails;
  logic [31:0] image [10];

  instruction_memory #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .addr        (addr),
    .instruction (instruction),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata)
  );

  // Clock runs only once enabled, so the first reads happen with no edges.
  initial clk = 1'b0;
  always #5 begin
    if (clk_en) clk = ~clk;
    else        clk = 1'b0;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input string tag, input logic [31:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check();
    logic [31:0] e;
    string       t;
    vectors++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL scoreboard: observed=%h required=<queued value>", instruction);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (instruction === e) else begin
        fails++;
        $error("FAIL %s: observed=%h required=%h", t, instruction, e);
      end
    end
  endtask

  // Combinational read: set addr, queue expectation, settle, compare.
  task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] e);
    addr = a;
    push(tag, e);
    #1;
    check();
  endtask

  initial begin
    vectors = 0;
    fails   = 0;
    clk_en  = 1'b0;
    rst_n   = 1'b1;
    we      = 1'b0;
    waddr   = 32'h0;
    wdata   = 32'h0;
    addr    = 32'h0;
    image[0] = 32'h0050_0113; image[1] = 32'h0070_0193;
    image[2] = 32'h0631_0463; image[3] = 32'h0031_01b3;
    image[4] = 32'h0031_62b3; image[5] = 32'h0031_72b3;
    image[6] = 32'h0031_42b3; image[7] = 32'h0001_2503;
    image[8] = 32'h00a1_2223; image[9] = 32'h4031_43b3;

    // Power-up image, no clock edges yet.
    for (int i = 0; i < 10; i++) begin
      read_chk($sformatf("image_w%0d", i), 32'(i * 4), image[i]);
    end
    read_chk("beyond_0x28", 32'h0000_0028, NOP);
    read_chk("beyond_0x40", 32'h0000_0040, NOP);
    read_chk("last_word_nop", 32'h0000_03FC, NOP);
    read_chk("oor_depth", 32'h0000_0400, NOP);
    read_chk("oor_max", 32'hFFFF_FFFC, NOP);
    read_chk("lowbits_0x06", 32'h0000_0006, image[1]);
    read_chk("lowbits_0x03", 32'h0000_0003, image[0]);

    // Start clocking; write word 16 and check old-then-new around the edge.
    clk_en = 1'b1;
    @(negedge clk);
    we = 1'b1; waddr = 32'h0000_0040; wdata = 32'hDEAD_BEEF;
    read_chk("pre_write_old", 32'h0000_0040, NOP);
    push("post_write_new", 32'hDEAD_BEEF);
    @(posedge clk); #1;
    check();
    we = 1'b0;

    // Write with nonzero byte offset lands on the whole word.
    @(negedge clk);
    we = 1'b1; waddr = 32'h0000_0027; wdata = 32'h1111_2222;
    @(posedge clk); #1;
    we = 1'b0;
    read_chk("offset_write_w9", 32'h0000_0024, 32'h1111_2222);
    read_chk("offset_write_w8", 32'h0000_0020, image[8]);

    // Reset with a coincident write: read path stays live before the edge.
    @(negedge clk);
    rst_n = 1'b0; we = 1'b1; waddr = 32'h0000_0000; wdata = 32'h1234_5678;
    read_chk("rst_read_live", 32'h0000_0040, 32'hDEAD_BEEF);
    addr = 32'h0000_0040;
    push("rst_restore_w16", NOP);
    @(posedge clk); #1;
    check();
    read_chk("rst_drop_write_w0", 32'h0000_0000, image[0]);
    read_chk("rst_restore_w9", 32'h0000_0024, image[9]);
    @(negedge clk);
    rst_n = 1'b1; we = 1'b0;

    // Highest in-range word is writable.
    @(negedge clk);
    we = 1'b1; waddr = 32'h0000_03FC; wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    we = 1'b0;
    read_chk("write_last_word", 32'h0000_03FC, 32'hA5A5_A5A5);

    // Out-of-range write is dropped without wrap-around.
    @(negedge clk);
    we = 1'b1; waddr = 32'(DEPTH * 4); wdata = 32'hCAFE_BABE;
    @(posedge clk); #1;
    we = 1'b0;
    read_chk("oor_write_w0", 32'h0000_0000, image[0]);
    read_chk("oor_write_last", 32'h0000_03FC, 32'hA5A5_A5A5);
    read_chk("oor_write_read", 32'(DEPTH * 4), NOP);
    read_chk("oor_write_w1", 32'h0000_0004, image[1]);

    // we=0 must not write.
    @(negedge clk);
    we = 1'b0; waddr = 32'h0000_000C; wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    read_chk("no_we_w3", 32'h0000_000C, image[3]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/instruction_memory.md
INSTRUCTION_MEMORY -- requirements
Module: instruction_memory

Interface
REQ-001 Parameter DEPTH, default 256; number of 32-bit instruction words stored.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 addr  input  32  byte address (PC) of the instruction to fetch.
REQ-005 instruction  output  32  instruction word at addr.
REQ-006 we  input  1  write enable for program loading, active-high.
REQ-007 waddr  input  32  byte address of the word to write.
REQ-008 wdata  input  32  instruction word to write.

Function
REQ-009 The read path SHALL be purely combinational: instruction reflects addr within the same cycle, with no clock edge required.
REQ-010 The word index SHALL be addr[31:2]; addr[1:0] SHALL be ignored, so 0x05 reads the same word as 0x04.
REQ-011 A read with word index >= DEPTH SHALL return the NOP encoding 32'h00000013.
REQ-012 The default program image SHALL be as follows; every other word SHALL hold 32'h00000013:
- word 0: 00500113
- word 1: 00700193
- word 2: 06310463
- word 3: 003101b3
- word 4: 003162b3
- word 5: 003172b3
- word 6: 003142b3
- word 7: 00012503
- word 8: 00a12223
- word 9: 403143b3
REQ-013 The memory SHALL hold the default image from time zero (power-up initialisation), before any clock edge or reset.
REQ-014 On a rising clk edge with rst_n=1 and we=1, word waddr[31:2] SHALL be written with wdata, if that index is < DEPTH.
REQ-015 A write whose index is >= DEPTH SHALL be ignored, with no aliasing or wrap-around.
REQ-016 waddr[1:0] SHALL be ignored; only whole-word writes are supported.
REQ-017 Read during write to the same word: instruction SHALL show the old value until the edge and the new value immediately after it (no bypass).
REQ-018 The output SHALL never be X or Z for any addr value, including addresses beyond DEPTH.

Reset
REQ-019 On a rising clk edge with rst_n=0, all DEPTH words SHALL be restored to the default image of REQ-012.
REQ-020 A write (we=1) coinciding with the reset edge SHALL be discarded; reset takes priority.
REQ-021 Reset SHALL NOT gate the read path: instruction stays combinationally valid while rst_n=0.
REQ-022 A reset asserted after writes have been made SHALL undo all of them at the next rising edge.

Verification
REQ-023 Without any clock: addr = 0x00, 0x04, ... 0x24 in turn, 1 ns settle each -> instruction = the 10 image words in order (00500113 ... 403143b3).
REQ-024 addr=0x40 -> 00000013; addr=0x28 -> 00000013; addr=0xFFFFFFFC -> 00000013 (beyond DEPTH).
REQ-025 addr=0x06 -> 00700193; addr=0x03 -> 00500113 (low address bits ignored).
REQ-026 Write sequence:
- we=1, waddr=0x40, wdata=DEADBEEF, one clk edge.
- Then addr=0x40 -> DEADBEEF.
- Before that edge, addr=0x40 -> 00000013.
REQ-027 Reset sequence:
- After REQ-026, rst_n=0 together with we=1, waddr=0x00, wdata=12345678, one edge.
- Then addr=0x40 -> 00000013 and addr=0x00 -> 00500113.
REQ-028 Out-of-range write: we=1, waddr=DEPTH*4, wdata=CAFEBABE, one edge -> addr=0x00 still 00500113, no stored word changed.
